// File: rtl/rvfpm_pipe_checker.sv
// Protocol checker for the rvfpm FP pipeline: shadows issued instructions, checks retire timing/rd, counts classes.
// Optional stall watchdog: define RVFPM_CHK_STALL_TIMEOUT_EN.
module rvfpm_pipe_checker #(
    parameter int NUM_REGS        = 32,
    parameter int PIPELINE_STAGES = 4,
    parameter int CNT_W           = 16,
    parameter int STALL_LIMIT     = 64,
    localparam int RD_W           = $clog2(NUM_REGS),
    localparam int IF_W           = $clog2(PIPELINE_STAGES + 1)
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             enable,
    input  logic             issue_valid,
    input  logic [31:0]      issue_instr,
    input  logic             ret_valid,
    input  logic [RD_W-1:0]  ret_rd,
    input  logic             chk_clear,
    output logic [CNT_W-1:0] error_cnt,
    output logic             error_flag,
    output logic [2:0]       err_code,
    output logic [IF_W-1:0]  in_flight,
    output logic [CNT_W-1:0] cnt_load,
    output logic [CNT_W-1:0] cnt_store,
    output logic [CNT_W-1:0] cnt_arith
);

    localparam int P = PIPELINE_STAGES;

    localparam logic [6:0] OP_FLW    = 7'b0000111;
    localparam logic [6:0] OP_FSW    = 7'b0100111;
    localparam logic [6:0] OP_FP     = 7'b1010011;
    localparam logic [6:0] OP_FMADD  = 7'b1000011;
    localparam logic [6:0] OP_FMSUB  = 7'b1000111;
    localparam logic [6:0] OP_FNMSUB = 7'b1001011;
    localparam logic [6:0] OP_FNMADD = 7'b1001111;

    localparam logic [2:0] E_NONE = 3'd0;

    // valid/ready-free protocol: issue_valid and ret_valid are single-cycle qualifiers,
    // meaningful only together with enable; the DUT has no backpressure beyond enable.
    logic          is_load, is_store, is_arith, is_illegal, accept;
    logic [P-1:0]  s_valid, s_valid_nxt;
    logic [RD_W-1:0] s_rd     [P];
    logic [RD_W-1:0] s_rd_nxt [P];
    logic [IF_W-1:0] pop_nxt;
    logic          exp_valid;
    logic [RD_W-1:0] exp_rd;
    logic [7:1]    err_vec;
    logic [2:0]    err_sel;
    logic          err_hit;
    logic          timeout_hit;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        is_arith = 1'b0;
        case (issue_instr[6:0])
            OP_FLW:                                     is_load  = 1'b1;
            OP_FSW:                                     is_store = 1'b1;
            OP_FP, OP_FMADD, OP_FMSUB, OP_FNMSUB, OP_FNMADD: is_arith = 1'b1;
            default: ;
        endcase
    end

    assign is_illegal = !(is_load || is_store || is_arith);
    assign accept     = issue_valid && enable;
    assign exp_valid  = s_valid[P-1];
    assign exp_rd     = s_rd[P-1];

    // Stores never write back, so only loads and arith ops occupy a shadow slot.
    always_comb begin
        s_valid_nxt = s_valid;
        for (int i = 0; i < P; i++) s_rd_nxt[i] = s_rd[i];
        if (enable) begin
            for (int i = P - 1; i > 0; i--) begin
                s_valid_nxt[i] = s_valid[i-1];
                s_rd_nxt[i]    = s_rd[i-1];
            end
            s_valid_nxt[0] = issue_valid && (is_load || is_arith);
            s_rd_nxt[0]    = issue_instr[7 +: RD_W];
        end
    end

    always_comb begin
        pop_nxt = '0;
        for (int i = 0; i < P; i++) pop_nxt = pop_nxt + IF_W'(s_valid_nxt[i]);
    end

    always_comb begin
        err_vec[1] = enable && exp_valid && !ret_valid;
        err_vec[2] = enable && !exp_valid && ret_valid;
        err_vec[3] = enable && exp_valid && ret_valid && (ret_rd != exp_rd);
        err_vec[4] = !enable && ret_valid;
        err_vec[5] = timeout_hit;
        err_vec[6] = !enable && issue_valid;
        err_vec[7] = accept && is_illegal;
    end

    // Scan downwards so the lowest raised code is the one kept.
    always_comb begin
        err_sel = E_NONE;
        for (int c = 7; c >= 1; c--) begin
            if (err_vec[c]) err_sel = 3'(c);
        end
    end

    assign err_hit = |err_vec;

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            s_valid   <= '0;
            for (int i = 0; i < P; i++) s_rd[i] <= '0;
            in_flight <= '0;
        end else begin
            s_valid   <= s_valid_nxt;
            for (int i = 0; i < P; i++) s_rd[i] <= s_rd_nxt[i];
            in_flight <= pop_nxt;
        end
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            error_cnt  <= '0;
            error_flag <= 1'b0;
            err_code   <= E_NONE;
            cnt_load   <= '0;
            cnt_store  <= '0;
            cnt_arith  <= '0;
        end else if (chk_clear) begin
            error_cnt  <= '0;
            error_flag <= 1'b0;
            err_code   <= E_NONE;
            cnt_load   <= '0;
            cnt_store  <= '0;
            cnt_arith  <= '0;
        end else begin
            if (accept && is_load)  cnt_load  <= sat_inc(cnt_load);
            if (accept && is_store) cnt_store <= sat_inc(cnt_store);
            if (accept && is_arith) cnt_arith <= sat_inc(cnt_arith);
            if (err_hit) begin
                error_cnt  <= sat_inc(error_cnt);
                error_flag <= 1'b1;
                err_code   <= err_sel;
            end
        end
    end

`ifdef RVFPM_CHK_STALL_TIMEOUT_EN
    localparam int SC_W = $clog2(STALL_LIMIT + 1);

    logic [SC_W-1:0] stall_cnt;
    logic            stall_fired;

    // Fires on the STALL_LIMIT-th stalled cycle; stays quiet until the pipe advances again.
    assign timeout_hit = !enable && (in_flight != '0) && !stall_fired &&
                         (stall_cnt == SC_W'(STALL_LIMIT - 1));

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            stall_cnt   <= '0;
            stall_fired <= 1'b0;
        end else if (enable) begin
            stall_cnt   <= '0;
            stall_fired <= 1'b0;
        end else if (in_flight == '0) begin
            stall_cnt   <= '0;
        end else begin
            if (stall_cnt != SC_W'(STALL_LIMIT)) stall_cnt <= stall_cnt + SC_W'(1);
            if (timeout_hit) stall_fired <= 1'b1;
        end
    end

    logic unused_bits;
    assign unused_bits = ^issue_instr;
`else
    assign timeout_hit = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{issue_instr, STALL_LIMIT[0]};
`endif

endmodule

// File: tb/tb_rvfpm_pipe_checker.sv
// Bench for rvfpm_pipe_checker: directed vector table, corner sequences and random traffic vs an age-based model.
// Timeout checks follow RVFPM_CHK_STALL_TIMEOUT_EN.
module tb_rvfpm_pipe_checker;

  localparam int NUM_REGS = 32;
  localparam int P        = 4;
  localparam int CNT_W    = 4;
  localparam int LIMIT    = 64;
  localparam int RD_W     = 5;
  localparam int IF_W     = 3;
  localparam int CMAX     = (1 << CNT_W) - 1;

  localparam logic [31:0] FADD = 32'h002081D3;  // fadd.s f3,f1,f2
  localparam logic [31:0] FSW  = 32'h0020A427;
  localparam logic [31:0] ADDI = 32'h002081B3;  // integer OP, illegal here
  localparam logic [31:0] FLW  = 32'h0000A107;  // rd = 2

  // clock / reset
  logic ck = 1'b0;
  logic rst = 1'b0;
  always #5 ck = ~ck;

  logic             enable, issue_valid, ret_valid, chk_clear;
  logic [31:0]      issue_instr;
  logic [RD_W-1:0]  ret_rd;
  logic [CNT_W-1:0] error_cnt, cnt_load, cnt_store, cnt_arith;
  logic             error_flag;
  logic [2:0]       err_code;
  logic [IF_W-1:0]  in_flight;

  rvfpm_pipe_checker #(
    .NUM_REGS(NUM_REGS), .PIPELINE_STAGES(P), .CNT_W(CNT_W), .STALL_LIMIT(LIMIT)
  ) dut (
    .ck(ck), .rst(rst), .enable(enable), .issue_valid(issue_valid),
    .issue_instr(issue_instr), .ret_valid(ret_valid), .ret_rd(ret_rd),
    .chk_clear(chk_clear), .error_cnt(error_cnt), .error_flag(error_flag),
    .err_code(err_code), .in_flight(in_flight), .cnt_load(cnt_load),
    .cnt_store(cnt_store), .cnt_arith(cnt_arith)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // reference model: list of in-flight writebacks with age in enabled edges
  typedef struct { logic [RD_W-1:0] rd; int age; } item_t;
  item_t q[$];
  int m_err_cnt, m_err_code, m_flag, m_load, m_store, m_arith;
  int m_stall;
  bit m_fired;

  function automatic int op_class(input logic [6:0] op);  // 1 load, 2 store, 3 arith, 0 illegal
    case (op)
      7'b0000111: return 1;
      7'b0100111: return 2;
      7'b1010011, 7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic model_reset();
    q.delete();
    m_err_cnt = 0; m_err_code = 0; m_flag = 0;
    m_load = 0; m_store = 0; m_arith = 0;
    m_stall = 0; m_fired = 0;
  endtask

  task automatic compare_model(input string tag);
    check({tag, "_error_cnt"}, int'(error_cnt), m_err_cnt);
    check({tag, "_error_flag"}, int'(error_flag), m_flag);
    check({tag, "_err_code"}, int'(err_code), m_err_code);
    check({tag, "_in_flight"}, int'(in_flight), q.size());
    check({tag, "_cnt_load"}, int'(cnt_load), m_load);
    check({tag, "_cnt_store"}, int'(cnt_store), m_store);
    check({tag, "_cnt_arith"}, int'(cnt_arith), m_arith);
  endtask

  // driver: apply one cycle of inputs, advance the model, then compare after the edge
  task automatic step(input logic en, input logic iv, input logic [31:0] instr,
                      input logic rv, input logic [RD_W-1:0] rrd, input logic clr);
    bit due;
    logic [RD_W-1:0] due_rd;
    bit [7:1] cand;
    int code, cls;
    item_t it;
    enable = en; issue_valid = iv; issue_instr = instr;
    ret_valid = rv; ret_rd = rrd; chk_clear = clr;

    due = 0; due_rd = '0;
    foreach (q[i]) if (q[i].age == P) begin due = 1; due_rd = q[i].rd; end
    cls = op_class(instr[6:0]);
    cand = '0;
    cand[1] = en && due && !rv;
    cand[2] = en && !due && rv;
    cand[3] = en && due && rv && (rrd != due_rd);
    cand[4] = !en && rv;
    cand[6] = !en && iv;
    cand[7] = en && iv && (cls == 0);
`ifdef RVFPM_CHK_STALL_TIMEOUT_EN
    if (en) begin
      m_stall = 0; m_fired = 0;
    end else if (q.size() == 0) begin
      m_stall = 0;
    end else begin
      m_stall++;
      if (m_stall == LIMIT && !m_fired) begin cand[5] = 1; m_fired = 1; end
    end
`endif
    code = 0;
    for (int c = 1; c <= 7; c++) if (cand[c] && code == 0) code = c;

    if (clr) begin
      m_err_cnt = 0; m_flag = 0; m_err_code = 0;
      m_load = 0; m_store = 0; m_arith = 0;
    end else begin
      if (code != 0) begin m_err_cnt = sat(m_err_cnt); m_flag = 1; m_err_code = code; end
      if (en && iv && cls == 1) m_load = sat(m_load);
      if (en && iv && cls == 2) m_store = sat(m_store);
      if (en && iv && cls == 3) m_arith = sat(m_arith);
    end
    if (en) begin
      foreach (q[i]) q[i].age++;
      for (int i = q.size() - 1; i >= 0; i--) if (q[i].age > P) q.delete(i);
      if (iv && (cls == 1 || cls == 3)) begin
        it.rd = instr[11:7]; it.age = 1;
        q.push_back(it);
      end
    end

    @(posedge ck); #1;
    compare_model("mdl");
  endtask

  task automatic idle(input logic en);
    step(en, 1'b0, 32'h0, 1'b0, '0, 1'b0);
  endtask

  task automatic mid_reset();
    enable = 0; issue_valid = 0; ret_valid = 0; chk_clear = 0;
    rst = 1'b0;
    model_reset();
    #2;
    compare_model("rst");
    @(posedge ck); #1;
    rst = 1'b1;
  endtask

  // directed vector table
  typedef struct {
    logic en, iv; logic [31:0] instr; logic rv; logic [RD_W-1:0] rrd; logic clr;
    int e_cnt, e_code, e_flag, e_inf, e_ar, e_st, e_ld;
  } vec_t;
  vec_t vt[$];

  task automatic add(input logic en, input logic iv, input logic [31:0] instr,
                     input logic rv, input logic [RD_W-1:0] rrd, input logic clr,
                     input int ec, input int code, input int fl, input int inf,
                     input int ar, input int st, input int ld);
    vec_t v;
    v.en = en; v.iv = iv; v.instr = instr; v.rv = rv; v.rrd = rrd; v.clr = clr;
    v.e_cnt = ec; v.e_code = code; v.e_flag = fl; v.e_inf = inf;
    v.e_ar = ar; v.e_st = st; v.e_ld = ld;
    vt.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic [6:0]  op;
    logic        en, iv, rv, clr, due;
    logic [RD_W-1:0] rrd, due_rd;
    int k;

    enable = 0; issue_valid = 0; issue_instr = '0;
    ret_valid = 0; ret_rd = '0; chk_clear = 0;
    model_reset();
    repeat (3) @(posedge ck);
    #1;
    compare_model("reset");
    rst = 1'b1;

    //   en iv instr  rv rd clr | cnt code flag inflight arith store load
    add(1, 1, FADD, 0, 0, 0,  0, 0, 0, 1, 1, 0, 0);   // good retire 4 cycles later
    add(1, 0, 0,    0, 0, 0,  0, 0, 0, 1, 1, 0, 0);
    add(1, 0, 0,    0, 0, 0,  0, 0, 0, 1, 1, 0, 0);
    add(1, 0, 0,    0, 0, 0,  0, 0, 0, 1, 1, 0, 0);
    add(1, 0, 0,    1, 3, 0,  0, 0, 0, 0, 1, 0, 0);
    add(1, 1, FADD, 0, 0, 0,  0, 0, 0, 1, 2, 0, 0);   // late retire
    add(1, 0, 0,    0, 0, 0,  0, 0, 0, 1, 2, 0, 0);
    add(1, 0, 0,    0, 0, 0,  0, 0, 0, 1, 2, 0, 0);
    add(1, 0, 0,    0, 0, 0,  0, 0, 0, 1, 2, 0, 0);
    add(1, 0, 0,    0, 0, 0,  1, 1, 1, 0, 2, 0, 0);
    add(1, 0, 0,    1, 3, 0,  2, 2, 1, 0, 2, 0, 0);
    add(1, 0, 0,    0, 0, 1,  0, 0, 0, 0, 0, 0, 0);
    add(1, 1, FADD, 0, 0, 0,  0, 0, 0, 1, 1, 0, 0);   // stall mid-flight
    add(1, 0, 0,    0, 0, 0,  0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0,    0, 0, 0,  0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0,    0, 0, 0,  0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0,    0, 0, 0,  0, 0, 0, 1, 1, 0, 0);
    add(1, 0, 0,    0, 0, 0,  0, 0, 0, 1, 1, 0, 0);
    add(1, 0, 0,    0, 0, 0,  0, 0, 0, 1, 1, 0, 0);
    add(1, 0, 0,    1, 3, 0,  0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0,    1, 0, 0,  1, 4, 1, 0, 1, 0, 0);   // retire during stall
    add(0, 1, FADD, 0, 0, 0,  2, 6, 1, 0, 1, 0, 0);   // issue during stall
    add(1, 1, FSW,  0, 0, 0,  2, 6, 1, 0, 1, 1, 0);
    add(1, 0, 0,    0, 0, 0,  2, 6, 1, 0, 1, 1, 0);
    add(1, 0, 0,    0, 0, 0,  2, 6, 1, 0, 1, 1, 0);
    add(1, 0, 0,    0, 0, 0,  2, 6, 1, 0, 1, 1, 0);
    add(1, 0, 0,    1, 5, 0,  3, 2, 1, 0, 1, 1, 0);
    add(1, 1, ADDI, 0, 0, 0,  4, 7, 1, 0, 1, 1, 0);
    add(1, 1, FLW,  0, 0, 0,  4, 7, 1, 1, 1, 1, 1);
    add(1, 0, 0,    0, 0, 0,  4, 7, 1, 1, 1, 1, 1);
    add(1, 0, 0,    0, 0, 0,  4, 7, 1, 1, 1, 1, 1);
    add(1, 0, 0,    0, 0, 0,  4, 7, 1, 1, 1, 1, 1);
    add(1, 0, 0,    1, 7, 0,  5, 3, 1, 0, 1, 1, 1);   // rd mismatch
    add(0, 1, FADD, 1, 0, 0,  6, 4, 1, 0, 1, 1, 1);   // codes 4 and 6: lowest kept
    add(0, 0, 0,    1, 0, 1,  0, 0, 0, 0, 0, 0, 0);   // clear beats error

    foreach (vt[i]) begin
      step(vt[i].en, vt[i].iv, vt[i].instr, vt[i].rv, vt[i].rrd, vt[i].clr);
      check($sformatf("vec%0d_error_cnt", i), int'(error_cnt), vt[i].e_cnt);
      check($sformatf("vec%0d_err_code", i), int'(err_code), vt[i].e_code);
      check($sformatf("vec%0d_error_flag", i), int'(error_flag), vt[i].e_flag);
      check($sformatf("vec%0d_in_flight", i), int'(in_flight), vt[i].e_inf);
      check($sformatf("vec%0d_cnt_arith", i), int'(cnt_arith), vt[i].e_ar);
      check($sformatf("vec%0d_cnt_store", i), int'(cnt_store), vt[i].e_st);
      check($sformatf("vec%0d_cnt_load", i), int'(cnt_load), vt[i].e_ld);
    end

    // error counter saturation
    repeat (20) step(1, 0, 32'h0, 1, '0, 0);
    check("sat_error_cnt", int'(error_cnt), 15);
    check("sat_err_code", int'(err_code), 2);
    step(1, 0, 32'h0, 0, '0, 1);
    check("clr_error_cnt", int'(error_cnt), 0);
    check("clr_error_flag", int'(error_flag), 0);

    // long stall with one entry in flight
    step(1, 1, FADD, 0, '0, 0);
    for (int s = 1; s <= 70; s++) begin
      idle(0);
`ifdef RVFPM_CHK_STALL_TIMEOUT_EN
      if (s == 63) check("to_before_limit", int'(error_cnt), 0);
      if (s == 64) check("to_at_limit", int'(err_code), 5);
`endif
    end
`ifdef RVFPM_CHK_STALL_TIMEOUT_EN
    check("to_once_cnt", int'(error_cnt), 1);
`else
    check("no_timeout_cnt", int'(error_cnt), 0);
`endif
    check("stall_in_flight", int'(in_flight), 1);
    idle(1); idle(1); idle(1);
    step(1, 0, 32'h0, 1, 5'd3, 0);
    check("drain_in_flight", int'(in_flight), 0);
    step(1, 0, 32'h0, 0, '0, 1);

    // reset with work in flight drops the expectation silently
    step(1, 1, FADD, 0, '0, 0);
    idle(1);
    mid_reset();
    repeat (6) idle(1);
    check("rst_no_missing", int'(error_cnt), 0);
    check("rst_in_flight", int'(in_flight), 0);

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      en  = ($urandom_range(0, 9) < 8);
      iv  = ($urandom_range(0, 9) < 4);
      clr = ($urandom_range(0, 49) == 0);
      r = $urandom();
      k = $urandom_range(0, 7);
      case (k)
        0: op = 7'b0000111;
        1: op = 7'b0100111;
        2: op = 7'b1010011;
        3: op = 7'b1000011;
        4: op = 7'b1000111;
        5: op = 7'b1001011;
        6: op = 7'b1001111;
        default: op = r[6:0];
      endcase
      due = 0; due_rd = '0;
      foreach (q[i]) if (q[i].age == P) begin due = 1; due_rd = q[i].rd; end
      rrd = RD_W'($urandom_range(0, NUM_REGS - 1));
      if (en && due) begin
        k = $urandom_range(0, 19);
        rv = (k != 0);
        if (k > 1) rrd = due_rd;
      end else begin
        rv = ($urandom_range(0, 19) == 0);
      end
      step(en, iv, {r[31:7], op}, rv, rrd, clr);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
